mem_initiator: RTL and testbench

Synthesizable initiator for the Phaethon RAM request/acknowledge protocol. Core load/store commands are queued in a small FIFO and issued one at a time as single-cycle `readReq`/`writeReq` pulses. Each command is tracked until `readAck`/`writeAck` arrives or a timeout expires, and a one-cycle response is returned to the core. The block sits between the ALU datapath and the RAM responder, and is the issuing end of the same handshake the RAM model answers.

---
 rtl/mem_initiator_pkg.sv | 26 ++
 rtl/mem_cmd_fifo.sv | 70 +++++++
 rtl/mem_initiator.sv | 172 +++++++++++++++++
 tb/tb_mem_initiator.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared types for the Phaethon RAM initiator: FSM encoding, default timeout,
// and the layout of a queued core command.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT = 16;

    // One queued command is {write, address, data}, write in the MSB.
    localparam int CMD_W         = 65;
    localparam int CMD_DATA_LSB  = 0;
    localparam int CMD_ADDR_LSB  = 32;
    localparam int CMD_WRITE_BIT = 64;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] data;
    } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; push is refused when full
// and pop is ignored when empty, so callers may request either unconditionally.
module mem_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are power-of-two wide, so the natural overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Issues queued core load/store commands to the RAM responder one at a time,
// waits for the matching ack or a timeout, and returns a one-cycle response.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic                          cmdWrite,
    input  logic [31:0]                   cmdAddress,
    input  logic [31:0]                   cmdData,
    output logic                          rspValid,
    output logic [31:0]                   rspData,
    output logic                          rspError,
    output logic [31:0]                   ramAddress,
    output logic [31:0]                   ramOut,
    output logic                          readReq,
    output logic                          writeReq,
    input  logic [31:0]                   ramValue,
    input  logic                          readAck,
    input  logic                          writeAck,
    output logic [1:0]                    dbgState,
    output logic [$clog2(FIFO_DEPTH):0]   dbgCount
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    state_e             state_q, state_d;
    logic               write_q, write_d;
    logic [31:0]        ram_address_q, ram_address_d;
    logic [31:0]        ram_out_q, ram_out_d;
    logic               read_req_q, read_req_d;
    logic               write_req_q, write_req_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_error_q, rsp_error_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CMD_W-1:0]   fifo_din, fifo_dout;
    cmd_t               head;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PTR_W:0]     fifo_count;
    logic               ack_match;

    // Handshake: a command transfers on a rising edge where cmdValid and
    // cmdReady are both high; cmdReady reflects registered occupancy only, so
    // a full queue refuses even when the head is popped in that same cycle.
    assign cmdReady  = !fifo_full;
    assign fifo_push = cmdValid && !fifo_full;

    always_comb begin
        fifo_din = '0;
        fifo_din[CMD_WRITE_BIT]      = cmdWrite;
        fifo_din[CMD_ADDR_LSB +: 32] = cmdAddress;
        fifo_din[CMD_DATA_LSB +: 32] = cmdData;
    end

    assign head = cmd_t'(fifo_dout);

    mem_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign ack_match = write_q ? writeAck : readAck;

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        ram_address_d = ram_address_q;
        ram_out_d     = ram_out_q;
        read_req_d    = 1'b0;
        write_req_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        cnt_d         = cnt_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    write_d       = head.write;
                    ram_address_d = head.address;
                    ram_out_d     = head.data;
                    read_req_d    = !head.write;
                    write_req_d   = head.write;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = write_q ? 32'h0 : ramValue;
                    rsp_error_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    // Abandon: any ack that shows up later lands outside WAIT.
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            ram_address_q <= '0;
            ram_out_q     <= '0;
            read_req_q    <= 1'b0;
            write_req_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            ram_address_q <= ram_address_d;
            ram_out_q     <= ram_out_d;
            read_req_q    <= read_req_d;
            write_req_q   <= write_req_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ramAddress = ram_address_q;
    assign ramOut     = ram_out_q;
    assign readReq    = read_req_q;
    assign writeReq   = write_req_q;
    assign rspValid   = rsp_valid_q;
    assign rspData    = rsp_data_q;
    assign rspError   = rsp_error_q;
    assign dbgState   = state_q;
    assign dbgCount   = fifo_count;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator against a one-cycle-latency RAM responder
// model; a negedge monitor checks responses against an expected queue.
module tb_mem_initiator;
    import mem_initiator_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int TIMEOUT    = 16;

    logic                        clk;
    logic                        reset;
    logic                        cmdValid;
    logic                        cmdReady;
    logic                        cmdWrite;
    logic [31:0]                 cmdAddress;
    logic [31:0]                 cmdData;
    logic                        rspValid;
    logic [31:0]                 rspData;
    logic                        rspError;
    logic [31:0]                 ramAddress;
    logic [31:0]                 ramOut;
    logic                        readReq;
    logic                        writeReq;
    logic [31:0]                 ramValue;
    logic                        readAck;
    logic                        writeAck;
    logic [1:0]                  dbgState;
    logic [$clog2(FIFO_DEPTH):0] dbgCount;

    logic [32:0] exp_q[$];
    int          req_cyc_q[$];
    logic        req_wr_q[$];
    logic [31:0] req_addr_q[$];
    int          rsp_cyc_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int mode  = 0;
    logic inject_rd = 1'b0;

    mem_initiator #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdWrite   (cmdWrite),
        .cmdAddress (cmdAddress),
        .cmdData    (cmdData),
        .rspValid   (rspValid),
        .rspData    (rspData),
        .rspError   (rspError),
        .ramAddress (ramAddress),
        .ramOut     (ramOut),
        .readReq    (readReq),
        .writeReq   (writeReq),
        .ramValue   (ramValue),
        .readAck    (readAck),
        .writeAck   (writeAck),
        .dbgState   (dbgState),
        .dbgCount   (dbgCount)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM responder model ----------------
    // mode 0: ack one cycle after the request is latched
    // mode 1: never ack
    // mode 2: reads get a bogus writeAck first, then the readAck three cycles later
    logic [7:0]  ram [0:1023];
    logic [31:0] rd_val;
    int          rd_cd, wr_cd;
    logic        bogus;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {ram[a[9:0] + 10'd3], ram[a[9:0] + 10'd2], ram[a[9:0] + 10'd1], ram[a[9:0]]};
    endfunction

    assign ramValue = rd_val;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            readAck  <= 1'b0;
            writeAck <= 1'b0;
            rd_val   <= '0;
            rd_cd    <= 0;
            wr_cd    <= 0;
            bogus    <= 1'b0;
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            {ram[19],  ram[18],  ram[17],  ram[16]}  <= 32'hDEADBEEF;
            {ram[259], ram[258], ram[257], ram[256]} <= 32'hA5A50001;
            {ram[263], ram[262], ram[261], ram[260]} <= 32'hA5A50002;
            {ram[83],  ram[82],  ram[81],  ram[80]}  <= 32'h0BADF00D;
        end else begin
            readAck  <= 1'b0;
            writeAck <= 1'b0;
            if (rd_cd == 1) readAck <= 1'b1;
            if (rd_cd > 0) rd_cd <= rd_cd - 1;
            if (wr_cd == 1) writeAck <= 1'b1;
            if (wr_cd > 0) wr_cd <= wr_cd - 1;
            if (bogus) begin
                writeAck <= 1'b1;
                bogus    <= 1'b0;
            end
            if (inject_rd) readAck <= 1'b1;
            if (readReq && mode != 1) begin
                rd_val <= rd_word(ramAddress);
                rd_cd  <= (mode == 2) ? 4 : 1;
                bogus  <= (mode == 2);
            end
            if (writeReq && mode != 1) begin
                {ram[ramAddress[9:0] + 10'd3], ram[ramAddress[9:0] + 10'd2],
                 ram[ramAddress[9:0] + 10'd1], ram[ramAddress[9:0]]} <= ramOut;
                wr_cd <= 1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic        prev_req = 1'b0;
    logic        infl = 1'b0;
    logic [31:0] infl_addr, infl_out;
    logic [31:0] wack_out = '0;
    logic [32:0] e;

    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
            infl     = 1'b0;
        end else begin
            if (readReq || writeReq) begin
                check("req_single_cycle", 64'(prev_req), 64'd0);
                check("req_onehot", 64'(readReq & writeReq), 64'd0);
                req_cyc_q.push_back(cyc);
                req_wr_q.push_back(writeReq);
                req_addr_q.push_back(ramAddress);
                infl      = 1'b1;
                infl_addr = ramAddress;
                infl_out  = ramOut;
            end else if (infl) begin
                check("ram_address_stable", 64'(ramAddress), 64'(infl_addr));
                check("ram_out_stable", 64'(ramOut), 64'(infl_out));
            end
            if (writeAck) wack_out = ramOut;
            if (rspValid) begin
                infl = 1'b0;
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got err=%0d data=0x%0h, expected no response",
                             rspError, rspData);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_error", 64'(rspError), 64'(e[32]));
                    check("rsp_data", 64'(rspData), 64'(e[31:0]));
                end
            end
            prev_req = readReq || writeReq;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int pc);
        int budget = 100;
        cmdValid   = 1'b1;
        cmdWrite   = w;
        cmdAddress = a;
        cmdData    = d;
        while (!cmdReady && budget > 0) begin
            tick(1);
            budget--;
        end
        if (!cmdReady) begin
            n_vec++;
            n_err++;
            $display("FAIL push_ready_timeout: got cmdReady=0, expected 1 within 100 cycles");
        end
        tick(1);
        pc       = cyc;
        cmdValid = 1'b0;
    endtask

    task automatic wait_rsp(input int k);
        int budget = 200;
        while (rsp_cyc_q.size() < k && budget > 0) begin
            tick(1);
            budget--;
        end
        if (rsp_cyc_q.size() < k) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_wait_timeout: got %0d responses, expected %0d", rsp_cyc_q.size(), k);
        end
    endtask

    task automatic clear_logs();
        req_cyc_q.delete();
        req_wr_q.delete();
        req_addr_q.delete();
        rsp_cyc_q.delete();
    endtask

    // ---------------- directed tests ----------------
    int p, p0, p1, p2, p3;

    initial begin
        reset      = 1'b1;
        cmdValid   = 1'b0;
        cmdWrite   = 1'b0;
        cmdAddress = '0;
        cmdData    = '0;

        #1;
        check("rst_ctrl", 64'({cmdReady, rspValid, rspError, readReq, writeReq}), 64'b10000);
        check("rst_rsp_data", 64'(rspData), 64'd0);
        check("rst_ram_address", 64'(ramAddress), 64'd0);
        check("rst_ram_out", 64'(ramOut), 64'd0);
        check("rst_state", 64'(dbgState), 64'(ST_IDLE));
        check("rst_count", 64'(dbgCount), 64'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        // Load
        clear_logs();
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        push_cmd(1'b0, 32'h10, $urandom, p);
        wait_rsp(1);
        tick(1);
        check("load_req_count", 64'(req_cyc_q.size()), 64'd1);
        check("load_req_cyc", 64'(req_cyc_q[0]), 64'(p + 1));
        check("load_req_kind", 64'(req_wr_q[0]), 64'd0);
        check("load_req_addr", 64'(req_addr_q[0]), 64'h10);
        check("load_rsp_cyc", 64'(rsp_cyc_q[0]), 64'(p + 4));

        // Store
        clear_logs();
        exp_q.push_back({1'b0, 32'h0});
        push_cmd(1'b1, 32'h20, 32'h12345678, p);
        wait_rsp(1);
        tick(1);
        check("store_req_cyc", 64'(req_cyc_q[0]), 64'(p + 1));
        check("store_req_kind", 64'(req_wr_q[0]), 64'd1);
        check("store_ramout_at_ack", 64'(wack_out), 64'h12345678);
        check("store_rsp_cyc", 64'(rsp_cyc_q[0]), 64'(p + 4));
        check("store_ram_word", 64'({ram[35], ram[34], ram[33], ram[32]}), 64'h12345678);
        check("store_ram_byte0", 64'(ram[32]), 64'h78);

        // Back-to-back: queue fills, a push is refused in the same cycle as a pop
        clear_logs();
        exp_q.push_back({1'b0, 32'hA5A50001});
        exp_q.push_back({1'b0, 32'hA5A50002});
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        push_cmd(1'b0, 32'h100, $urandom, p0);
        push_cmd(1'b0, 32'h104, $urandom, p1);
        push_cmd(1'b1, 32'h108, 32'hCAFEF00D, p2);
        check("b2b_push1_cyc", 64'(p1), 64'(p0 + 1));
        check("b2b_push2_cyc", 64'(p2), 64'(p0 + 2));
        check("b2b_ready_low_full", 64'(cmdReady), 64'd0);
        check("b2b_count_full", 64'(dbgCount), 64'd2);
        push_cmd(1'b0, 32'h108, $urandom, p3);
        check("b2b_push3_cyc", 64'(p3), 64'(p0 + 7));
        wait_rsp(4);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check("b2b_req_cyc", 64'(req_cyc_q[i]), 64'(p0 + 1 + 5 * i));
            check("b2b_rsp_cyc", 64'(rsp_cyc_q[i]), 64'(p0 + 4 + 5 * i));
        end

        // Timeout, then a late readAck while idle
        clear_logs();
        mode = 1;
        exp_q.push_back({1'b1, 32'h0});
        push_cmd(1'b0, 32'h40, $urandom, p);
        tick(8);
        check("timeout_in_wait", 64'(dbgState), 64'(ST_WAIT));
        wait_rsp(1);
        check("timeout_rsp_cyc", 64'(rsp_cyc_q[0]), 64'(p + TIMEOUT + 3));
        tick(2);
        inject_rd = 1'b1;
        tick(1);
        inject_rd = 1'b0;
        tick(10);
        check("late_ack_rsp_count", 64'(rsp_cyc_q.size()), 64'd1);
        check("late_ack_outputs_held", 64'({rspError, rspData}), 64'({1'b1, 32'h0}));
        check("late_ack_state", 64'(dbgState), 64'(ST_IDLE));

        // Wrong ack ignored, matching ack completes
        clear_logs();
        mode = 2;
        exp_q.push_back({1'b0, 32'h0BADF00D});
        push_cmd(1'b0, 32'h50, $urandom, p);
        wait_rsp(1);
        tick(1);
        check("wrong_ack_rsp_cyc", 64'(rsp_cyc_q[0]), 64'(p + 7));

        // Reset while waiting with one command still queued
        clear_logs();
        mode = 1;
        push_cmd(1'b0, 32'h60, $urandom, p);
        push_cmd(1'b1, 32'h64, 32'h55, p1);
        tick(4);
        check("pre_rst_state", 64'(dbgState), 64'(ST_WAIT));
        check("pre_rst_count", 64'(dbgCount), 64'd1);
        check("pre_rst_addr", 64'(ramAddress), 64'h60);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ctrl", 64'({cmdReady, rspValid, rspError, readReq, writeReq}), 64'b10000);
        check("async_rst_rsp_data", 64'(rspData), 64'd0);
        check("async_rst_ram_address", 64'(ramAddress), 64'd0);
        check("async_rst_ram_out", 64'(ramOut), 64'd0);
        check("async_rst_state", 64'(dbgState), 64'(ST_IDLE));
        check("async_rst_count", 64'(dbgCount), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode  = 0;
        clear_logs();
        tick(25);
        check("post_rst_rsp_count", 64'(rsp_cyc_q.size()), 64'd0);
        check("post_rst_req_count", 64'(req_cyc_q.size()), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
